// File: rtl/adder_sub_seq.sv
// -----------------------------------------------------------------------------
// adder_sub_seq
// Command sequencer for the adder_sub datapath. It accepts one add or subtract
// command over a valid/ready handshake and drives the operands and enables into
// adder_sub. It then waits for out_en, captures {carry_out, data_out} and
// presents the captured result on a valid/ready port. A carry register lets
// multi-byte add/sub chains be issued as back-to-back commands.
//
// Optional build macro: ADDER_SUB_SEQ_TIMEOUT_EN
//   When defined, a SAMPLE-state wait counter aborts after WAIT_MAX cycles
//   without out_en. The sequencer then returns an error result: data 0,
//   carry 0, res_err 1, and the stored carry is left unchanged.
//   When undefined, SAMPLE waits indefinitely and res_err is tied to 0.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_a, cmd_b            operands
//   cmd_op                  0 = add, 1 = subtract
//   cmd_chain               1 = use stored carry as carry_in
//   as_a, as_b              operands to adder_sub
//   as_add_en, as_sub_en    enables to adder_sub (mutually exclusive)
//   as_carry_in             carry_in to adder_sub
//   as_data_out,
//   as_carry_out, as_out_en results from adder_sub
//   res_valid/res_ready     result handshake
//   res_data, res_carry     captured result
//   res_err                 timeout flag (0 when the option is compiled out)
//
// state  | meaning
// IDLE   | ready for a command, datapath enables low
// DRIVE  | operands/enable driven, one settle cycle
// SAMPLE | enables held, waiting for adder_sub out_en
// RESULT | result presented, waiting for res_ready
// -----------------------------------------------------------------------------
module adder_sub_seq #(
  parameter int WIDTH    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_op,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_add_en,
  output logic             as_sub_en,
  output logic             as_carry_in,
  input  logic [WIDTH-1:0] as_data_out,
  input  logic             as_carry_out,
  input  logic             as_out_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("adder_sub_seq: WAIT_MAX must be at least 1");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_cin;
  logic             r_carry;
  logic             r_cmd_ready;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_carry;

  logic w_accept;
  logic w_active;
  logic w_capture;
  logic w_timeout;

  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_active  = (r_state == S_DRIVE) | (r_state == S_SAMPLE);
  assign w_capture = (r_state == S_SAMPLE) & as_out_en;

`ifdef ADDER_SUB_SEQ_TIMEOUT_EN
  localparam int WAIT_CW = $clog2(WAIT_MAX + 1);

  logic [WAIT_CW-1:0] r_wait;
  logic               r_res_err;

  // The WAIT_MAX-th empty SAMPLE cycle is the one that times out.
  assign w_timeout = (r_state == S_SAMPLE) & ~as_out_en &
                     (r_wait == WAIT_CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= '0;
      r_res_err <= 1'b0;
    end else begin
      if (r_state == S_DRIVE) begin
        r_wait <= '0;
      end else if ((r_state == S_SAMPLE) && !as_out_en && !w_timeout) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_capture) begin
        r_res_err <= 1'b0;
      end else if (w_timeout) begin
        r_res_err <= 1'b1;
      end
    end
  end

  assign res_err = r_res_err;
`else
  assign w_timeout = 1'b0;
  assign res_err   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_SAMPLE;
      S_SAMPLE: if (w_capture || w_timeout) w_next = S_RESULT;
      S_RESULT: if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_cin       <= 1'b0;
      r_carry     <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Registered so ready stays low throughout reset and rises on the
      // first edge after release.
      r_cmd_ready <= (w_next == S_IDLE);
      if (w_accept) begin
        r_a   <= cmd_a;
        r_b   <= cmd_b;
        r_op  <= cmd_op;
        r_cin <= cmd_chain & r_carry;
      end
      if (w_capture) begin
        r_res_data  <= as_data_out;
        r_res_carry <= as_carry_out;
        r_carry     <= as_carry_out;
      end else if (w_timeout) begin
        r_res_data  <= '0;
        r_res_carry <= 1'b0;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign as_a        = r_a;
  assign as_b        = r_b;
  assign as_add_en   = w_active & ~r_op;
  assign as_sub_en   = w_active & r_op;
  assign as_carry_in = r_cin;
  assign res_valid   = (r_state == S_RESULT);
  assign res_data    = r_res_data;
  assign res_carry   = r_res_carry;

endmodule

// File: tb/tb_adder_sub_seq.sv
module tb_adder_sub_seq;
  localparam int W        = 8;
  localparam int WAIT_MAX = 15;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_op;
  logic         cmd_chain;
  logic [W-1:0] as_a;
  logic [W-1:0] as_b;
  logic         as_add_en;
  logic         as_sub_en;
  logic         as_carry_in;
  logic [W-1:0] as_data_out;
  logic         as_carry_out;
  logic         as_out_en;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_carry;
  logic         res_err;

  int n_vec = 0;
  int n_err = 0;
  logic m_carry = 1'b0;

  adder_sub_seq #(.WIDTH(W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .as_a(as_a), .as_b(as_b), .as_add_en(as_add_en), .as_sub_en(as_sub_en),
    .as_carry_in(as_carry_in), .as_data_out(as_data_out),
    .as_carry_out(as_carry_out), .as_out_en(as_out_en),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer arithmetic result: bit W is carry (add) or borrow (sub).
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic op, input logic cin);
    int r;
    if (op) r = int'(a) - int'(b) - int'(cin);
    else    r = int'(a) + int'(b) + int'(cin);
    return r[W:0];
  endfunction

  // Stand-in adder_sub: out_en rises once enables have been high oe_delay edges.
  int oe_delay = 1;
  int en_cnt = 0;
  logic w_en;
  logic [W:0] w_as_res;
  assign w_en = as_add_en | as_sub_en;
  assign w_as_res = ref_op(as_a, as_b, as_sub_en, as_carry_in);
  assign as_data_out = w_as_res[W-1:0];
  assign as_carry_out = w_as_res[W];
  assign as_out_en = w_en && (en_cnt >= oe_delay);
  always @(posedge clk) en_cnt <= w_en ? en_cnt + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, input logic chain);
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = W'($urandom); cmd_b = W'($urandom);
    cmd_op = 1'($urandom); cmd_chain = 1'($urandom);
  endtask

  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input logic chain,
                         input int delay, input int bp,
                         input logic [W-1:0] exp_d, input logic exp_c,
                         input logic exp_cin, input logic exp_e, input int exp_lat);
    int lat;
    bit drv_ok;
    bit bp_ok;
    bit seen;
    oe_delay = delay;
    issue(a, b, op, chain);
    lat = 1; drv_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      drv_ok &= (as_add_en === ~op) && (as_sub_en === op) && (as_a === a) &&
                (as_b === b) && (as_carry_in === exp_cin) && (cmd_ready === 1'b0);
      @(posedge clk);
      lat++;
    end
    check("res_valid_seen", seen, 1);
    check("drive_outputs", drv_ok, 1);
    check("latency", lat, exp_lat);
    check("res_data", res_data, exp_d);
    check("res_carry", res_carry, exp_c);
    check("res_err", res_err, exp_e);
    if (bp > 0) begin
      bp_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        bp_ok &= (res_valid === 1'b1) && (res_data === exp_d) && (res_carry === exp_c) &&
                 (cmd_ready === 1'b0) && (as_add_en === 1'b0) && (as_sub_en === 1'b0);
      end
      check("backpressure_hold", bp_ok, 1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("release_to_idle", {res_valid, cmd_ready}, 2'b01);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_carry = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         chain;
    int           delay;
    int           bp;
    logic [W-1:0] d;
    logic         c;
    logic         cin;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rop, rch, rcin;
    int rdel, rbp;
    bit quiet;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1, 0, 8'h80, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 1, 0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 1, 0, 8'h01, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b0, 1, 5, 8'h30, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 8'h03, 1'b1, 1'b0, 1, 0, 8'h02, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h01, 1'b1, 1'b0, 3, 0, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 2, 1, 8'h01, 1'b0, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = 1'b0; cmd_chain = 1'b0;
    #1;
    check("reset_outputs",
          {cmd_ready, as_a, as_b, as_add_en, as_sub_en, as_carry_in,
           res_valid, res_data, res_carry, res_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cmd_ready_low_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    check("cmd_ready_after_first_edge", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].chain, tbl[i].delay, tbl[i].bp,
              tbl[i].d, tbl[i].c, tbl[i].cin, 1'b0, tbl[i].delay + 2);
      m_carry = tbl[i].c;
    end

    // cmd_valid dropped without acceptance while busy: must be ignored.
    oe_delay = 2;
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 8'hEE;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
    check("busy_ignores_cmd", {res_valid, res_data, res_carry}, {1'b1, 8'h33, 1'b0});
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    m_carry = 1'b0;

    // Reset during SAMPLE after carry has been set to 1.
    run_cmd(8'hFF, 8'h01, 1'b0, 1'b0, 1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 3);
    m_carry = 1'b1;
    oe_delay = 1000;
    issue(8'h5A, 8'hA5, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {cmd_ready, as_a, as_b, as_add_en, as_sub_en, as_carry_in,
           res_valid, res_data, res_carry, res_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_carry = 1'b0;
    #1;
    check("ready_low_after_release", cmd_ready, 0);
    @(posedge clk);
    #1;
    check("ready_one_edge_after_release", cmd_ready, 1);
    run_cmd(8'h10, 8'h01, 1'b0, 1'b1, 1, 0, 8'h11, 1'b0, 1'b0, 1'b0, 3);

    // out_en never arrives.
    run_cmd(8'hFF, 8'h01, 1'b0, 1'b0, 1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 3);
    m_carry = 1'b1;
`ifdef ADDER_SUB_SEQ_TIMEOUT_EN
    run_cmd(8'h12, 8'h34, 1'b0, 1'b0, 1000, 0, 8'h00, 1'b0, 1'b0, 1'b1, WAIT_MAX + 2);
    run_cmd(8'h00, 8'h00, 1'b0, 1'b1, 1, 0, 8'h01, 1'b0, 1'b1, 1'b0, 3);
    m_carry = 1'b0;
`else
    oe_delay = 1000;
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      quiet &= (res_valid === 1'b0) && (res_err === 1'b0) && (as_add_en === 1'b1);
    end
    check("no_timeout_waits", quiet, 1);
    pulse_reset();
    @(negedge clk);
`endif

    // Randomized commands against the arithmetic reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rop = 1'($urandom); rch = 1'($urandom);
      rdel = int'($urandom_range(1, 4));
      rbp = int'($urandom_range(0, 2));
      rcin = rch & m_carry;
      r = ref_op(ra, rb, rop, rcin);
      run_cmd(ra, rb, rop, rch, rdel, rbp, r[W-1:0], r[W], rcin, 1'b0, rdel + 2);
      m_carry = r[W];
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adder_sub_seq.md
Name: adder_sub_seq

Overview:
- Upstream command sequencer for the 8-bit adder_sub datapath.
- Accepts operand/opcode commands over a valid/ready handshake and drives A, B, add_en, sub_en and carry_in into adder_sub.
- Waits for adder_sub out_en, captures {carry_out, data_out} and presents it on a valid/ready result port.
- Keeps a carry register so multi-byte add/sub chains can be issued as back-to-back commands.

Parameters:
- WIDTH, 8, operand/result width; must match adder_sub.
- WAIT_MAX, 15, out_en timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  1  0 = add, 1 = subtract.
- cmd_chain  in  1  1 = use stored carry as carry_in; 0 = carry_in 0.
- as_a  out  WIDTH  to adder_sub A.
- as_b  out  WIDTH  to adder_sub B.
- as_add_en  out  1  to adder_sub add_en.
- as_sub_en  out  1  to adder_sub sub_en.
- as_carry_in  out  1  to adder_sub carry_in.
- as_data_out  in  WIDTH  from adder_sub data_out.
- as_carry_out  in  1  from adder_sub carry_out.
- as_out_en  in  1  from adder_sub out_en.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured data_out.
- res_carry  out  1  captured carry_out.
- res_err  out  1  timeout flag; 0 when the feature is compiled out.

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - State IDLE; carry register 0.
  - cmd_ready 0 while rst_n is low; 1 from the first clk edge after release.
  - as_a, as_b, as_add_en, as_sub_en, as_carry_in all 0.
  - res_valid, res_data, res_carry, res_err all 0.
- FSM states: IDLE, DRIVE, SAMPLE, RESULT.
- IDLE:
  - cmd_ready = 1; datapath enables 0.
  - On cmd_valid & cmd_ready, register cmd_a, cmd_b, cmd_op, and carry_in = cmd_chain ? carry_reg : 0. Go to DRIVE.
- DRIVE:
  - as_a/as_b driven from registers; as_add_en = ~op, as_sub_en = op. Never both high.
  - cmd_ready = 0. One settle cycle, then go to SAMPLE.
- SAMPLE:
  - Operands and enables held stable.
  - If as_out_en = 1: register as_data_out to res_data and as_carry_out to res_carry and carry_reg; res_err = 0; go to RESULT.
  - Otherwise stay in SAMPLE.
- RESULT:
  - res_valid = 1; enables 0; operand outputs keep their last values.
  - res_data/res_carry/res_err held stable until res_valid & res_ready; then res_valid drops next edge and state returns to IDLE.
- Latency: handshake at edge N, then DRIVE at N+1, SAMPLE at N+2; res_valid high after edge N+3 at minimum. Best-case throughput is one command per 4 cycles with res_ready held high.
- cmd_ready is low in DRIVE/SAMPLE/RESULT; no command is accepted while a result is pending.
- carry_reg updates only on a completed non-error capture. A chain after a timeout uses the last good carry.
- Width rules:
  - res_data is exactly WIDTH bits; res_carry is bit WIDTH of the sum.
  - carry_in is passed through verbatim for sub; its borrow semantics are defined by adder_sub.
- Reset asserted mid-operation: immediate return to reset values; the in-flight command is discarded and carry_reg is cleared.
- cmd_valid may drop without acceptance; no state change.

Optional Feature:
- Macro: ADDER_SUB_SEQ_TIMEOUT_EN.
- Defined:
  - A 4-bit counter (sized from WAIT_MAX) clears on entering SAMPLE and increments each SAMPLE cycle without as_out_en.
  - When it reaches WAIT_MAX: res_data = 0, res_carry = 0, res_err = 1, carry_reg unchanged, go to RESULT.
- Not defined: no counter; SAMPLE waits indefinitely; res_err tied 0.

Test Plan:
- Add, no chain: cmd_a = 0x7F, cmd_b = 0x01, op 0, with adder_sub out_en = 1 -> res_data 0x80, res_carry 0, res_valid at edge N+3, as_add_en = 1 and as_sub_en = 0 during DRIVE/SAMPLE.
- Carry chain: 0xFF + 0x01 (chain 0) gives 0x00/carry 1; then 0x00 + 0x00 (chain 1) -> as_carry_in = 1 and result 0x01/carry 0.
- Backpressure: res_ready held low 5 cycles after 0x10 + 0x20 -> res_valid stays high, res_data stays 0x30, cmd_ready stays 0; release gives IDLE next cycle.
- Subtract: 0x05 - 0x03, op 1 -> as_sub_en = 1, as_add_en = 0; res_data matches the adder_sub output 0x02.
- Timeout (macro on): as_out_en tied 0 -> after WAIT_MAX = 15 SAMPLE cycles, res_err 1, res_data 0x00, carry_reg unchanged. Macro off: res_valid never rises.
- Reset mid-operation: rst_n pulsed low during SAMPLE -> all outputs 0 asynchronously, cmd_ready 1 one edge after release; a subsequent chain command uses carry_in 0.
